// File: rtl/biset_regbank_pkg.sv
// biset_regbank_pkg: BiSet bus types, widths, CTRL bit positions and the command constructor
package biset_regbank_pkg;
  localparam int BISET_ADDR_W = 8;
  localparam int BISET_DATA_W = 16;
  typedef logic [BISET_ADDR_W-1:0] biSetAddr;
  typedef logic [BISET_DATA_W-1:0] biSetData;
  typedef biSetData biSetReply;
  localparam biSetAddr BISET_ADDR_MAX = '1;
  typedef struct packed {
    logic     en;
    logic     we;
    biSetAddr addr;
  } biSetCtrl;
  localparam int BISET_CTRL_COMMIT = 0;
  localparam int BISET_CTRL_ERRCLR = 1;
  localparam int BISET_STAT_ERR    = 0;
  localparam int BISET_STAT_DIRTY  = 1;
  function automatic biSetCtrl BiSetCtrl(input logic en, input logic we, input biSetAddr addr);
    BiSetCtrl = '{en: en, we: we, addr: addr};
  endfunction
endpackage

// File: rtl/biset_regbank_addr_decode.sv
// biset_addr_decode: classifies a BiSet address as cfg/status/CTRL/unmapped with a range-relative index
module biset_addr_decode import biset_regbank_pkg::*; #(
  parameter int       NREG      = 8,
  parameter int       NSTAT     = 4,
  parameter biSetAddr CTRL_ADDR = BISET_ADDR_MAX,
  parameter int       IDX_W     = 3
) (
  input  biSetAddr         addr,
  output logic             isCfg,
  output logic             isStat,
  output logic             isCtrl,
  output logic             isUnmapped,
  output logic [IDX_W-1:0] index
);
  // one extra bit so NREG+NSTAT equal to 2**BISET_ADDR_W cannot wrap
  localparam logic [BISET_ADDR_W:0] CFG_END  = (BISET_ADDR_W+1)'(NREG);
  localparam logic [BISET_ADDR_W:0] STAT_END = (BISET_ADDR_W+1)'(NREG + NSTAT);
  logic [BISET_ADDR_W:0] w_addr;
  always_comb begin
    w_addr     = {1'b0, addr};
    isCtrl     = addr == CTRL_ADDR;
    isCfg      = w_addr < CFG_END;
    isStat     = !isCfg && w_addr < STAT_END;
    isUnmapped = !(isCfg || isStat || isCtrl);
    index      = IDX_W'(isStat ? addr - biSetAddr'(NREG) : addr);
  end
endmodule

// File: rtl/biset_regbank.sv
// biset_regbank: BiSet target with NREG RW config regs, NSTAT RO status words and a CTRL register.
// Define BISET_REGBANK_SHADOW_EN to stage cfg writes in shadows applied by a CTRL commit.
module biset_regbank import biset_regbank_pkg::*; #(
  parameter int                  NREG      = 8,
  parameter int                  NSTAT     = 4,
  parameter biSetAddr            CTRL_ADDR = BISET_ADDR_MAX,
  parameter biSetData [NREG-1:0] RST_VAL   = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  biSetCtrl             setCtrl_i,
  input  biSetData             setWrite_i,
  output biSetReply            setReply_o,
  output biSetData [NREG-1:0]  cfg_o,
  output logic [NREG-1:0]      cfgStrobe_o,
  input  biSetData [NSTAT-1:0] status_i
);
  localparam int MAXN  = NREG > NSTAT ? NREG : NSTAT;
  localparam int IDX_W = MAXN > 1 ? $clog2(MAXN) : 1;
  if ({1'b0, CTRL_ADDR} < (BISET_ADDR_W+1)'(NREG + NSTAT)) begin : g_ctrl_overlap
    $error("biset_regbank: CTRL_ADDR overlaps the cfg/status range");
  end
  logic                w_cfg, w_stat, w_ctrl, w_unmap;
  logic [IDX_W-1:0]    w_idx;
  logic                w_wr, w_rd, w_err_set, w_err_clr, w_dirty_any;
  logic [NREG-1:0]     w_wsel;
  biSetData            w_cfg_rd, w_stat_rd, w_ctrl_rd, w_rd_data;
  biSetData [NREG-1:0] w_rd_src;
  biSetData [NREG-1:0] r_cfg;
  logic [NREG-1:0]     r_strobe;
  biSetReply           r_reply;
  logic                r_err;
  biset_addr_decode #(
    .NREG(NREG), .NSTAT(NSTAT), .CTRL_ADDR(CTRL_ADDR), .IDX_W(IDX_W)
  ) u_dec (
    .addr(setCtrl_i.addr), .isCfg(w_cfg), .isStat(w_stat), .isCtrl(w_ctrl),
    .isUnmapped(w_unmap), .index(w_idx)
  );
`ifdef BISET_REGBANK_SHADOW_EN
  biSetData [NREG-1:0] r_shadow;
  logic [NREG-1:0]     r_dirty;
  logic                w_commit;
  assign w_commit    = w_wr && w_ctrl && setWrite_i[BISET_CTRL_COMMIT];
  assign w_dirty_any = |r_dirty;
  assign w_rd_src    = r_shadow;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_shadow <= RST_VAL;
      r_dirty  <= '0;
      r_cfg    <= RST_VAL;
      r_strobe <= '0;
    end else begin
      r_strobe <= w_commit ? r_dirty : '0;
      r_dirty  <= w_commit ? '0 : r_dirty | w_wsel;
      for (int i = 0; i < NREG; i++) begin
        if (w_wsel[i]) r_shadow[i] <= setWrite_i;
        if (w_commit && r_dirty[i]) r_cfg[i] <= r_shadow[i];
      end
    end
  end
`else
  assign w_dirty_any = 1'b0;
  assign w_rd_src    = r_cfg;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cfg    <= RST_VAL;
      r_strobe <= '0;
    end else begin
      r_strobe <= w_wsel;
      for (int i = 0; i < NREG; i++)
        if (w_wsel[i]) r_cfg[i] <= setWrite_i;
    end
  end
`endif
  always_comb begin
    w_wr      = setCtrl_i.en && setCtrl_i.we;
    w_rd      = setCtrl_i.en && !setCtrl_i.we;
    w_err_set = setCtrl_i.en && (w_unmap || (w_wr && w_stat));
    w_err_clr = w_wr && w_ctrl && setWrite_i[BISET_CTRL_ERRCLR];
    w_wsel    = '0;
    w_cfg_rd  = '0;
    w_stat_rd = '0;
    for (int i = 0; i < NREG; i++) begin
      w_wsel[i] = w_wr && w_cfg && w_idx == IDX_W'(i);
      if (w_idx == IDX_W'(i)) w_cfg_rd = w_rd_src[i];
    end
    for (int j = 0; j < NSTAT; j++)
      if (w_idx == IDX_W'(j)) w_stat_rd = status_i[j];
    w_ctrl_rd                   = '0;
    w_ctrl_rd[BISET_STAT_ERR]   = r_err;
    w_ctrl_rd[BISET_STAT_DIRTY] = w_dirty_any;
    w_rd_data = w_cfg ? w_cfg_rd : w_stat ? w_stat_rd : w_ctrl ? w_ctrl_rd : '0;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_reply <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_rd) r_reply <= w_rd_data;
      r_err <= w_err_clr ? 1'b0 : w_err_set ? 1'b1 : r_err;
    end
  end
  assign setReply_o  = r_reply;
  assign cfg_o       = r_cfg;
  assign cfgStrobe_o = r_strobe;
endmodule

// File: doc/biset_regbank.md
Name: biset_regbank

Overview:
- BiSet target: consumes the BiSet control/write-data stream from a BiSet master (testbench driver or on-chip bridge) and returns read data on the reply bus.
- Holds NREG software-writable configuration registers and exposes them to the datapath, with a one-cycle update strobe per register.
- Maps NSTAT read-only status inputs into the same address space, plus one control/status register (CTRL).

Parameters:
- NREG, 8, number of RW config registers, addresses 0..NREG-1.
- NSTAT, 4, number of RO status words, addresses NREG..NREG+NSTAT-1.
- CTRL_ADDR, BISET_ADDR_MAX (all ones), address of CTRL register. Must not overlap the cfg or status ranges; checked by an elaboration assertion.
- RST_VAL, all-zero biSetData array [NREG], reset value of each config register.

Ports:
- clk_i, input, 1, clock.
- rst_i, input, 1, asynchronous active-high reset.
- setCtrl_i, input, biSetCtrl, command. Fields: en, we, addr. All-zero means idle.
- setWrite_i, input, biSetData, write data. Qualified by en=1 and we=1.
- setReply_o, output, biSetData, read data.
- cfg_o, output, biSetData x NREG, live configuration values.
- cfgStrobe_o, output, NREG, one-cycle pulse per register whose cfg_o changed value source this cycle.
- status_i, input, biSetData x NSTAT, datapath status, sampled on read.

Behaviour:
- Reset (async, rst_i=1):
  - setReply_o=0, cfg_o[i]=RST_VAL[i], cfgStrobe_o=0.
  - Shadow and dirty state cleared; errSticky=0.
  - A command in flight during reset is dropped. No strobe is produced on reset release.
- Command acceptance:
  - Every posedge with setCtrl_i.en=1 accepts exactly one command. No backpressure; back-to-back commands are legal.
- Read (en=1, we=0) sampled at edge k:
  - setReply_o is registered at edge k and is valid from edge k to the next read edge. This makes it stable at the negedge of the cycle following command issue.
  - Returned value by address:
    - cfg range: current cfg value (shadow value when BISET_REGBANK_SHADOW_EN is defined).
    - status range: status_i value at edge k.
    - CTRL: {0…, dirtyAny, errSticky}.
    - unmapped: 0, and errSticky is set.
  - Writes and idle cycles leave setReply_o unchanged.
- Write (en=1, we=1) at edge k:
  - cfg addr a: cfg_o[a] takes setWrite_i at edge k. cfgStrobe_o[a]=1 for the cycle k..k+1, including when the value is unchanged.
  - status addr: ignored, errSticky set.
  - unmapped: ignored, errSticky set.
  - CTRL: bit1=1 clears errSticky. Bit0 is the commit bit (shadow build only, see Optional Feature). Other bits are ignored.
- Clear and set of errSticky on the same edge cannot occur, because there is one command per cycle.
- Address compare uses the full biSetAddr width, with no aliasing or wrap. The cfg range test is addr < NREG, evaluated at BISET_ADDR_W+1 bits to avoid overflow.

Optional Feature:
- Macro: BISET_REGBANK_SHADOW_EN.
- Defined:
  - A cfg write updates shadow[a] and sets dirty[a]. cfg_o is unchanged and no strobe is produced.
  - A CTRL write with bit0=1 at edge k copies every dirty shadow to cfg_o at edge k. cfgStrobe_o pulses for exactly the dirty set, then dirty is cleared.
  - A commit with nothing dirty produces no strobe. Reads of the cfg range return shadow.
  - dirtyAny = |dirty.
  - Reset loads shadow = RST_VAL.
- Undefined:
  - No shadow or dirty storage; writes take effect immediately as described above.
  - CTRL bit0 is ignored; dirtyAny reads 0.

Decomposition:
- BiSet package holds:
  - biSetCtrl struct {en, we, addr}, biSetData, biSetAddr, biSetReply.
  - BISET_ADDR_W, BISET_DATA_W, BISET_ADDR_MAX.
  - BiSetCtrl() constructor.
  - CTRL bit constants BISET_CTRL_COMMIT=0 and BISET_CTRL_ERRCLR=1 (write), BISET_STAT_ERR=0 and BISET_STAT_DIRTY=1 (read).
- Sub-module biset_addr_decode (combinational): outputs isCfg, isStat, isCtrl, isUnmapped, and index. It is reused by future BiSet targets.

Test Plan:
- Reset with RST_VAL[2]=0x5A -> cfg_o[2]=0x5A, setReply_o=0, cfgStrobe_o=0 after release.
- Write addr 3 = 0x1234, then read addr 3 -> immediate build: cfg_o[3]=0x1234 with cfgStrobe_o=0b1000 for one cycle, reply 0x1234 at the negedge after the read command. Shadow build: no strobe, reply 0x1234.
- status_i[1]=0xBEEF held, read addr NREG+1 -> reply 0xBEEF. Change status_i after the read edge -> reply stays 0xBEEF until the next read.
- Read unmapped addr 0x40 -> reply 0. Then read CTRL -> bit0=1. Write CTRL 0x2, read CTRL -> bit0=0.
- Shadow build: write addr 0=0x1 and addr 5=0x2, then CTRL=0x1 -> cfg_o[0]=1 and cfg_o[5]=2 on the same edge, cfgStrobe_o=0b00100001 for one cycle. A second commit produces no strobe.
- Assert rst_i asynchronously in the middle of a write cycle -> outputs return to reset values immediately and no strobe follows reset release.
